ir_cam_sequencer: RTL and testbench

- Controller that owns the shared i2c_master and sequences the IR tracking camera.
- Pulses the camera reset, then writes the 6-pair init table to the camera, then loops forever: write pointer 0x36, read 16 bytes, decode blob 1, wait the poll interval.
- Decoded pen position feeds the drawing/pixel path downstream.
- Replaces ad-hoc per-state config handling with a table-driven loop plus a stall watchdog.

---
 rtl/ir_cam_sequencer.sv | 252 +++++++++++++++++++++++++
 tb/tb_ir_cam_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_cam_sequencer.sv
// IR tracking camera sequencer: owns the shared i2c_master, runs camera
// reset, table-driven init, then a pointer/read/decode/poll loop.
module ir_cam_sequencer #(
  parameter logic [6:0]  CAM_ADDR       = 7'h58,
  parameter int unsigned RST_CYCLES     = 1000,
  parameter int unsigned BOOT_CYCLES    = 100000,
  parameter int unsigned POLL_CYCLES    = 200000,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         i2c_ready,
  input  logic [127:0] i2c_data_out,
  output logic         i2c_start,
  output logic [6:0]   i2c_addr,
  output logic [127:0] i2c_data,
  output logic [4:0]   i2c_packets,
  output logic         i2c_rw,
  output logic         cam_reset,
  output logic [10:0]  x,
  output logic [10:0]  y,
  output logic [3:0]   blob_size,
  output logic         blob_valid,
  output logic         frame_strobe,
  output logic         init_done,
  output logic [7:0]   err_count
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CAM_RST,
    S_BOOT,
    S_CFG_START,
    S_CFG_BUSY,
    S_PTR_START,
    S_PTR_BUSY,
    S_RD_START,
    S_RD_BUSY,
    S_DECODE,
    S_POLL
  } state_e;

  localparam logic [31:0] RST_LAST  = 32'(RST_CYCLES - 1);
  localparam logic [31:0] BOOT_LAST = 32'(BOOT_CYCLES - 1);
  localparam logic [31:0] POLL_LAST = 32'(POLL_CYCLES - 1);
  localparam logic [31:0] WD_LIMIT  = 32'(TIMEOUT_CYCLES);

  function automatic logic [15:0] cfg_word(input logic [2:0] idx);
    logic [15:0] w;
    case (idx)
      3'd0:    w = 16'h3001;
      3'd1:    w = 16'h3008;
      3'd2:    w = 16'h0690;
      3'd3:    w = 16'h08C0;
      3'd4:    w = 16'h1A40;
      3'd5:    w = 16'h3333;
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  state_e         state_q, state_d;
  logic [2:0]     idx_q, idx_d;
  logic [31:0]    cnt_q, cnt_d;
  logic [127:0]   data_q, data_d;
  logic [4:0]     pkts_q, pkts_d;
  logic           rw_q, rw_d;
  logic [9:0]     x_q, x_d;
  logic [9:0]     y_q, y_d;
  logic [3:0]     size_q, size_d;
  logic           valid_q, valid_d;
  logic           strobe_q, strobe_d;
  logic           init_q, init_d;
  logic [7:0]     err_q, err_d;

  logic           is_start;
  logic           is_busy;
  logic           wd_fire;
  logic [7:0]     b1, b2, b3;

  assign is_start = (state_q == S_CFG_START) ||
                    (state_q == S_PTR_START) ||
                    (state_q == S_RD_START);
  assign is_busy  = (state_q == S_CFG_BUSY) ||
                    (state_q == S_PTR_BUSY) ||
                    (state_q == S_RD_BUSY);
  assign wd_fire  = (is_start || is_busy) && (cnt_q >= WD_LIMIT);

  assign b1 = i2c_data_out[15:8];
  assign b2 = i2c_data_out[23:16];
  assign b3 = i2c_data_out[31:24];

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    data_d   = data_q;
    pkts_d   = pkts_q;
    rw_d     = rw_q;
    x_d      = x_q;
    y_d      = y_q;
    size_d   = size_q;
    valid_d  = valid_q;
    strobe_d = 1'b0;
    init_d   = init_q;
    err_d    = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && i2c_ready) state_d = S_CAM_RST;
      end
      S_CAM_RST: begin
        if (!start)                 state_d = S_IDLE;
        else if (cnt_q >= RST_LAST) state_d = S_BOOT;
      end
      S_BOOT: begin
        if (!start) begin
          state_d = S_IDLE;
        end else if (cnt_q >= BOOT_LAST && i2c_ready) begin
          state_d = S_CFG_START;
          idx_d   = 3'd0;
        end
      end
      S_CFG_START: begin
        if (!i2c_ready) state_d = S_CFG_BUSY;
      end
      S_CFG_BUSY: begin
        if (i2c_ready) begin
          if (idx_q == 3'd5) begin
            init_d  = 1'b1;
            state_d = start ? S_PTR_START : S_IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = start ? S_CFG_START : S_IDLE;
          end
        end
      end
      S_PTR_START: begin
        if (!i2c_ready) state_d = S_PTR_BUSY;
      end
      S_PTR_BUSY: begin
        if (i2c_ready) state_d = start ? S_RD_START : S_IDLE;
      end
      S_RD_START: begin
        if (!i2c_ready) state_d = S_RD_BUSY;
      end
      S_RD_BUSY: begin
        // a finished read is always decoded, even if start has dropped
        if (i2c_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        x_d      = {b3[5:4], b1};
        y_d      = {b3[7:6], b2};
        size_d   = b3[3:0];
        valid_d  = !((b1 == 8'hFF) && (b2 == 8'hFF) && (b3 == 8'hFF));
        strobe_d = 1'b1;
        state_d  = start ? S_POLL : S_IDLE;
      end
      S_POLL: begin
        if (!start) begin
          state_d = S_IDLE;
        end else if (cnt_q >= POLL_LAST && i2c_ready) begin
          state_d = S_PTR_START;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // completion wins; the watchdog only aborts a state that would stay put
    if (wd_fire && (state_d == state_q)) begin
      state_d = S_CAM_RST;
      err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
    end

    if ((state_d == S_CAM_RST) && (state_q != S_CAM_RST)) init_d = 1'b0;

    if (state_d != state_q) begin
      unique case (state_d)
        S_CFG_START: begin
          data_d = {112'd0, cfg_word(idx_d)};
          pkts_d = 5'd2;
          rw_d   = 1'b0;
        end
        S_PTR_START: begin
          data_d = {120'd0, 8'h36};
          pkts_d = 5'd1;
          rw_d   = 1'b0;
        end
        S_RD_START: begin
          data_d = 128'd0;
          pkts_d = 5'd16;
          rw_d   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cnt_d = '0;
    if ((state_d == state_q) && (state_q != S_IDLE)) begin
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      pkts_q   <= '0;
      rw_q     <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      size_q   <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      init_q   <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      pkts_q   <= pkts_d;
      rw_q     <= rw_d;
      x_q      <= x_d;
      y_q      <= y_d;
      size_q   <= size_d;
      valid_q  <= valid_d;
      strobe_q <= strobe_d;
      init_q   <= init_d;
      err_q    <= err_d;
    end
  end

  assign i2c_start    = is_start && !wd_fire;
  assign i2c_addr     = CAM_ADDR;
  assign i2c_data     = data_q;
  assign i2c_packets  = pkts_q;
  assign i2c_rw       = rw_q;
  assign cam_reset    = (state_q != S_CAM_RST);
  assign x            = {1'b0, x_q};
  assign y            = {1'b0, y_q};
  assign blob_size    = size_q;
  assign blob_valid   = valid_q;
  assign frame_strobe = strobe_q;
  assign init_done    = init_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_ir_cam_sequencer.sv
// Bench for ir_cam_sequencer: i2c master model, transaction-order model
// and blob decode model, with short timing parameters.
module tb_ir_cam_sequencer;

  localparam int RST_C  = 10;
  localparam int BOOT_C = 20;
  localparam int POLL_C = 30;
  localparam int TO_C   = 100;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         i2c_ready;
  logic [127:0] i2c_data_out;
  logic         i2c_start;
  logic [6:0]   i2c_addr;
  logic [127:0] i2c_data;
  logic [4:0]   i2c_packets;
  logic         i2c_rw;
  logic         cam_reset;
  logic [10:0]  x;
  logic [10:0]  y;
  logic [3:0]   blob_size;
  logic         blob_valid;
  logic         frame_strobe;
  logic         init_done;
  logic [7:0]   err_count;

  ir_cam_sequencer #(
    .CAM_ADDR      (7'h58),
    .RST_CYCLES    (RST_C),
    .BOOT_CYCLES   (BOOT_C),
    .POLL_CYCLES   (POLL_C),
    .TIMEOUT_CYCLES(TO_C)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .start       (start),
    .i2c_ready   (i2c_ready),
    .i2c_data_out(i2c_data_out),
    .i2c_start   (i2c_start),
    .i2c_addr    (i2c_addr),
    .i2c_data    (i2c_data),
    .i2c_packets (i2c_packets),
    .i2c_rw      (i2c_rw),
    .cam_reset   (cam_reset),
    .x           (x),
    .y           (y),
    .blob_size   (blob_size),
    .blob_valid  (blob_valid),
    .frame_strobe(frame_strobe),
    .init_done   (init_done),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [15:0] cfg_tbl [6] = '{16'h3001, 16'h3008, 16'h0690,
                               16'h08C0, 16'h1A40, 16'h3333};

  function automatic logic [127:0] exp_data(input int step);
    if (step < 6)  return {112'd0, cfg_tbl[step]};
    if (step == 6) return 128'h36;
    return 128'd0;
  endfunction

  function automatic int exp_pk(input int step);
    if (step < 6)  return 2;
    if (step == 6) return 1;
    return 16;
  endfunction

  // master/monitor state, written only by the monitor block
  logic         stuck = 1'b0;
  logic         wd_test = 1'b0;
  int           cyc = 0;
  int           busy_left = 0;
  logic [127:0] cur_data, pend, last_rd;
  logic [4:0]   cur_pk;
  logic         cur_rw;
  int           exp_step = 0;
  int           low_len = 0;
  logic         prev_cam = 1'b1;
  int           cam_pulses = 0;
  int           strobes = 0;
  logic         prev_strobe = 1'b0;
  int           txn_cnt = 0;
  logic         rd_busy = 1'b0;
  logic         have_strobe = 1'b0;
  int           strobe_cyc = 0;
  int           start_run = 0;
  int           hs_bad = 0;
  int           unstable = 0;
  logic [127:0] rd_q[$];

  initial begin
    logic [127:0] d;
    int b1, b2, b3;
    i2c_ready    = 1'b1;
    i2c_data_out = '0;
    cur_data = '0; cur_pk = '0; cur_rw = 1'b0;
    pend = '0; last_rd = '0;
    d = {$urandom, $urandom, $urandom, $urandom};
    d[31:8] = 24'hB51234;
    rd_q.push_back(d);
    d = {$urandom, $urandom, $urandom, $urandom};
    d[31:8] = 24'hFFFFFF;
    rd_q.push_back(d);
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        i2c_ready = 1'b1;
        busy_left = 0;
        exp_step  = 0;
        low_len   = 0;
        prev_cam  = 1'b1;
        rd_busy   = 1'b0;
        start_run = 0;
      end else begin
        if (!cam_reset) begin
          if (prev_cam) begin
            cam_pulses++;
            exp_step    = 0;
            have_strobe = 1'b0;
          end
          low_len++;
        end else if (low_len > 0) begin
          chk("cam_rst_len", 128'(low_len), 128'(RST_C));
          low_len = 0;
        end
        prev_cam = cam_reset;

        if (stuck && i2c_start) begin
          start_run++;
        end else begin
          if (start_run > 0 && wd_test)
            chk("wd_start_cycles", 128'(start_run), 128'(TO_C));
          start_run = 0;
        end

        if (frame_strobe) begin
          chk("strobe_1cyc", 128'(prev_strobe), 128'(0));
          b1 = int'(last_rd[15:8]);
          b2 = int'(last_rd[23:16]);
          b3 = int'(last_rd[31:24]);
          chk("dec_x", 128'(x), 128'(((b3 / 16) % 4) * 256 + b1));
          chk("dec_y", 128'(y), 128'((b3 / 64) * 256 + b2));
          chk("dec_size", 128'(blob_size), 128'(b3 % 16));
          chk("dec_valid", 128'(blob_valid),
              128'(!(b1 == 255 && b2 == 255 && b3 == 255)));
          strobes++;
          have_strobe = 1'b1;
          strobe_cyc  = cyc;
        end
        prev_strobe = frame_strobe;

        if (busy_left > 0) begin
          if (i2c_start) hs_bad++;
          if (i2c_data !== cur_data || i2c_packets !== cur_pk ||
              i2c_rw !== cur_rw) unstable++;
          busy_left--;
          if (busy_left == 0) begin
            i2c_ready = 1'b1;
            if (cur_rw) begin
              i2c_data_out = pend;
              last_rd      = pend;
              rd_busy      = 1'b0;
            end
          end
        end else if (i2c_ready && i2c_start && !stuck) begin
          chk("txn_addr", 128'(i2c_addr), 128'(7'h58));
          chk("txn_data", i2c_data, exp_data(exp_step));
          chk("txn_pk", 128'(i2c_packets), 128'(exp_pk(exp_step)));
          chk("txn_rw", 128'(i2c_rw), 128'(exp_step == 7));
          if (exp_step == 6) begin
            chk("init_done_ptr", 128'(init_done), 128'(1));
            if (have_strobe)
              chk("poll_gap", 128'(cyc - strobe_cyc >= POLL_C), 128'(1));
          end else if (exp_step < 6) begin
            chk("init_done_cfg", 128'(init_done), 128'(0));
          end
          cur_data  = i2c_data;
          cur_pk    = i2c_packets;
          cur_rw    = i2c_rw;
          txn_cnt++;
          i2c_ready = 1'b0;
          busy_left = int'($urandom_range(4, 24));
          if (i2c_rw) begin
            if (rd_q.size() > 0) pend = rd_q.pop_front();
            else pend = {$urandom, $urandom, $urandom, $urandom};
            rd_busy = 1'b1;
          end
          exp_step = (exp_step == 7) ? 6 : exp_step + 1;
        end
      end
    end
  end

  task automatic wait_strobes(input int n, input int budget);
    int tgt;
    int k;
    tgt = strobes + n;
    k = 0;
    while (strobes < tgt && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_strobes", 128'(strobes >= tgt), 128'(1));
  endtask

  initial begin
    int k;
    int s0, t0, p0;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_i2c_start", 128'(i2c_start), 128'(0));
    chk("rst_i2c_data", i2c_data, 128'(0));
    chk("rst_i2c_packets", 128'(i2c_packets), 128'(0));
    chk("rst_i2c_rw", 128'(i2c_rw), 128'(0));
    chk("rst_cam_reset", 128'(cam_reset), 128'(1));
    chk("rst_x", 128'(x), 128'(0));
    chk("rst_y", 128'(y), 128'(0));
    chk("rst_blob_size", 128'(blob_size), 128'(0));
    chk("rst_blob_valid", 128'(blob_valid), 128'(0));
    chk("rst_frame_strobe", 128'(frame_strobe), 128'(0));
    chk("rst_init_done", 128'(init_done), 128'(0));
    chk("rst_err_count", 128'(err_count), 128'(0));

    rst_n = 1'b1;
    start = 1'b1;
    wait_strobes(5, 3000);
    chk("pulses_first", 128'(cam_pulses), 128'(1));

    // master ignores requests: watchdog must re-init the camera
    stuck   = 1'b1;
    wd_test = 1'b1;
    k = 0;
    while (err_count != 8'd1 && k < TO_C + POLL_C + 200) begin
      @(negedge clk);
      k++;
    end
    chk("wd_err_count", 128'(err_count), 128'(1));
    chk("wd_init_done", 128'(init_done), 128'(0));
    chk("wd_cam_reset", 128'(cam_reset), 128'(0));
    stuck   = 1'b0;
    wd_test = 1'b0;
    wait_strobes(2, 3000);
    chk("pulses_wd", 128'(cam_pulses), 128'(2));

    // drop start mid-read: the read finishes, decodes once, then idles
    k = 0;
    while (!rd_busy && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("rd_busy_seen", 128'(rd_busy), 128'(1));
    start = 1'b0;
    s0 = strobes;
    k = 0;
    while (strobes == s0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    t0 = txn_cnt;
    repeat (3 * POLL_C) @(negedge clk);
    chk("stop_one_strobe", 128'(strobes), 128'(s0 + 1));
    chk("stop_no_txn", 128'(txn_cnt), 128'(t0));
    chk("stop_cam_idle", 128'(cam_reset), 128'(1));

    // restart, hold the first config request, then reset mid-request
    p0    = cam_pulses;
    stuck = 1'b1;
    start = 1'b1;
    k = 0;
    while (!(i2c_start && i2c_packets == 5'd2) && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("restart_pulse", 128'(cam_pulses), 128'(p0 + 1));
    chk("restart_cfg0", i2c_data, 128'h3001);
    chk("restart_init", 128'(init_done), 128'(0));
    rst_n = 1'b0;
    #1;
    chk("arst_i2c_start", 128'(i2c_start), 128'(0));
    chk("arst_i2c_data", i2c_data, 128'(0));
    chk("arst_i2c_packets", 128'(i2c_packets), 128'(0));
    chk("arst_cam_reset", 128'(cam_reset), 128'(1));
    chk("arst_err_count", 128'(err_count), 128'(0));
    chk("arst_x", 128'(x), 128'(0));
    chk("arst_blob_valid", 128'(blob_valid), 128'(0));

    chk("hs_start_in_busy", 128'(hs_bad), 128'(0));
    chk("hs_payload_stable", 128'(unstable), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
